// File: rtl/common_bus_datapath.sv
// Eight-bit common-bus datapath: PC, IR, 8x8 register file, ALU operand latches
// and flags, all loaded from one shared bus under microcode sequencer strobes.
package common_bus_pkg;
    typedef enum logic [2:0] {
        DB_ZERO      = 3'd0,
        DB_IR_R1     = 3'd1,
        DB_IR_R2     = 3'd2,
        DB_IR_RD     = 3'd3,
        DB_RF        = 3'd4,
        DB_ALU       = 3'd5,
        DB_PC_PLUS_4 = 3'd6
    } data_bus_t;
endpackage

module common_bus_datapath
    import common_bus_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  data_bus_t   data_bus_sel,
    input  logic        pc_load_en,
    input  logic        ir_load_en,
    input  logic        rf_write_read,
    input  logic        alu_src1_load_en,
    input  logic        alu_src2_load_en,
    input  logic        sel_field_load_en,
    input  logic [15:0] instr_data,
    output logic [7:0]  instr_addr,
    output logic        imm_instruction,
    output logic [7:0]  bus_value,
    output logic        zero_flag,
    output logic        carry_flag
);
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  rf_q [8];
    logic [7:0]  rf_d [8];
    logic [7:0]  src1_q, src1_d;
    logic [7:0]  src2_q, src2_d;
    logic [2:0]  sel_field_q, sel_field_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic [2:0]  alu_op_s;
    logic [2:0]  rd_s;
    logic [2:0]  r1_s;
    logic [5:0]  imm6_s;
    logic [8:0]  sum_s;
    logic [7:0]  alu_result_s;
    logic        alu_carry_s;
    logic [7:0]  bus_s;

    assign alu_op_s = ir_q[15:13];
    assign rd_s     = ir_q[11:9];
    assign r1_s     = ir_q[8:6];
    assign imm6_s   = ir_q[5:0];

    // ALU result and carry/borrow from the operand latches and the IR opcode
    always_comb begin
        sum_s        = {1'b0, src1_q} + {1'b0, src2_q};
        alu_result_s = 8'h00;
        alu_carry_s  = 1'b0;
        case (alu_op_s)
            3'd0: begin
                alu_result_s = sum_s[7:0];
                alu_carry_s  = sum_s[8];
            end
            3'd1: begin
                alu_result_s = src1_q - src2_q;
                alu_carry_s  = (src1_q < src2_q);
            end
            3'd2:    alu_result_s = src1_q & src2_q;
            3'd3:    alu_result_s = src1_q | src2_q;
            3'd4:    alu_result_s = src1_q ^ src2_q;
            3'd5:    alu_result_s = src1_q << src2_q[2:0];
            3'd6:    alu_result_s = src1_q >> src2_q[2:0];
            3'd7:    alu_result_s = src2_q;
            default: alu_result_s = 8'h00;
        endcase
    end

    // Common-bus source multiplexer; unused encodings drive zero
    always_comb begin
        bus_s = 8'h00;
        case (data_bus_sel)
            DB_ZERO:      bus_s = 8'h00;
            DB_IR_R1:     bus_s = {5'b00000, r1_s};
            DB_IR_R2:     bus_s = {2'b00, imm6_s};
            DB_IR_RD:     bus_s = {5'b00000, rd_s};
            DB_RF:        bus_s = rf_q[sel_field_q];
            DB_ALU:       bus_s = alu_result_s;
            DB_PC_PLUS_4: bus_s = pc_q + 8'd4;
            default:      bus_s = 8'h00;
        endcase
    end

    // Next-state: every strobe samples the same pre-edge bus and sel_field
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        rf_d        = rf_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        sel_field_d = sel_field_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        if (pc_load_en) pc_d = bus_s;
        else            pc_d = pc_q;
        if (ir_load_en) ir_d = instr_data;
        else            ir_d = ir_q;
        if (alu_src1_load_en) src1_d = bus_s;
        else                  src1_d = src1_q;
        if (alu_src2_load_en) src2_d = bus_s;
        else                  src2_d = src2_q;
        if (sel_field_load_en) sel_field_d = bus_s[2:0];
        else                   sel_field_d = sel_field_q;
        if (rf_write_read) rf_d[sel_field_q] = bus_s;
        else               rf_d = rf_q;
        // Flags only move on an ALU writeback
        if (rf_write_read && (data_bus_sel == DB_ALU)) begin
            zero_d  = (alu_result_s == 8'h00);
            carry_d = alu_carry_s;
        end else begin
            zero_d  = zero_q;
            carry_d = carry_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= 8'h00;
            ir_q        <= 16'h0000;
            for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
            src1_q      <= 8'h00;
            src2_q      <= 8'h00;
            sel_field_q <= 3'b000;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            sel_field_q <= sel_field_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
        end
    end

    assign instr_addr      = pc_q;
    assign imm_instruction = ir_q[12];
    assign bus_value       = bus_s;
    assign zero_flag       = zero_q;
    assign carry_flag      = carry_q;
endmodule

// File: tb/tb_common_bus_datapath.sv
// Bench for common_bus_datapath: directed instruction sequences plus random strobes,
// checked every cycle against an arithmetic reference model of the datapath.
module tb_common_bus_datapath;
    import common_bus_pkg::*;

    logic        clock;
    logic        reset_n;
    data_bus_t   data_bus_sel;
    logic        pc_load_en, ir_load_en, rf_write_read;
    logic        alu_src1_load_en, alu_src2_load_en, sel_field_load_en;
    logic [15:0] instr_data;
    logic [7:0]  instr_addr;
    logic        imm_instruction;
    logic [7:0]  bus_value;
    logic        zero_flag, carry_flag;

    logic [15:0] imem [256];
    int          checks = 0;
    int          errs   = 0;
    bit          cmp_en = 1'b0;

    common_bus_datapath dut (
        .clock(clock), .reset_n(reset_n), .data_bus_sel(data_bus_sel),
        .pc_load_en(pc_load_en), .ir_load_en(ir_load_en), .rf_write_read(rf_write_read),
        .alu_src1_load_en(alu_src1_load_en), .alu_src2_load_en(alu_src2_load_en),
        .sel_field_load_en(sel_field_load_en), .instr_data(instr_data),
        .instr_addr(instr_addr), .imm_instruction(imm_instruction),
        .bus_value(bus_value), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    assign instr_data = imem[instr_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural state
    logic [7:0]  m_pc, m_s1, m_s2, m_bus;
    logic [15:0] m_ir;
    logic [7:0]  m_rf [8];
    logic [2:0]  m_sf;
    logic        m_z, m_c;

    function automatic logic [7:0] alu_val(input logic [2:0] op, input logic [7:0] a8, input logic [7:0] b8);
        int a, b, r;
        a = int'(a8);
        b = int'(b8);
        case (op)
            3'd0: r = (a + b) % 256;
            3'd1: r = (a - b + 256) % 256;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (a * (1 << (b % 8))) % 256;
            3'd6: r = a / (1 << (b % 8));
            3'd7: r = b;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic alu_cy(input logic [2:0] op, input logic [7:0] a8, input logic [7:0] b8);
        case (op)
            3'd0:    return (int'(a8) + int'(b8)) > 255;
            3'd1:    return int'(a8) < int'(b8);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] model_bus(input logic [2:0] sel, input logic [7:0] pc,
                                             input logic [15:0] ir, input logic [7:0] rfv,
                                             input logic [7:0] s1, input logic [7:0] s2);
        int p;
        p = (int'(pc) + 4) % 256;
        case (sel)
            3'd0:    return 8'h00;
            3'd1:    return {5'd0, ir[8:6]};
            3'd2:    return {2'd0, ir[5:0]};
            3'd3:    return {5'd0, ir[11:9]};
            3'd4:    return rfv;
            3'd5:    return alu_val(ir[15:13], s1, s2);
            3'd6:    return p[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb m_bus = model_bus(data_bus_sel, m_pc, m_ir, m_rf[m_sf], m_s1, m_s2);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pc <= 8'h00; m_ir <= 16'h0000; m_s1 <= 8'h00; m_s2 <= 8'h00;
            m_sf <= 3'd0;  m_z  <= 1'b0;     m_c  <= 1'b0;
            for (int i = 0; i < 8; i++) m_rf[i] <= 8'h00;
        end else begin
            if (pc_load_en)        m_pc <= m_bus;
            if (ir_load_en)        m_ir <= imem[m_pc];
            if (alu_src1_load_en)  m_s1 <= m_bus;
            if (alu_src2_load_en)  m_s2 <= m_bus;
            if (sel_field_load_en) m_sf <= m_bus[2:0];
            if (rf_write_read)     m_rf[m_sf] <= m_bus;
            if (rf_write_read && data_bus_sel == DB_ALU) begin
                m_z <= (alu_val(m_ir[15:13], m_s1, m_s2) == 8'h00);
                m_c <= alu_cy(m_ir[15:13], m_s1, m_s2);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_instr_addr", {8'h00, instr_addr}, {8'h00, m_pc});
            chk("cyc_imm", {15'd0, imm_instruction}, {15'd0, m_ir[12]});
            chk("cyc_bus", {8'h00, bus_value}, {8'h00, m_bus});
            chk("cyc_zero", {15'd0, zero_flag}, {15'd0, m_z});
            chk("cyc_carry", {15'd0, carry_flag}, {15'd0, m_c});
        end
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic im, input logic [2:0] rd,
                                       input logic [2:0] r1, input logic [5:0] f);
        return {op, im, rd, r1, f};
    endfunction

    task automatic cyc(input data_bus_t s, input logic pc, input logic ir, input logic rfw,
                       input logic a1, input logic a2, input logic sf);
        data_bus_sel = s;  pc_load_en = pc; ir_load_en = ir; rf_write_read = rfw;
        alu_src1_load_en = a1; alu_src2_load_en = a2; sel_field_load_en = sf;
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input data_bus_t s, input string nm, input logic [7:0] exp);
        data_bus_sel = s;  pc_load_en = 1'b0; ir_load_en = 1'b0; rf_write_read = 1'b0;
        alu_src1_load_en = 1'b0; alu_src2_load_en = 1'b0; sel_field_load_en = 1'b0;
        #1;
        chk(nm, {8'h00, bus_value}, {8'h00, exp});
    endtask

    task automatic fetch(input logic [15:0] w);
        imem[m_pc] = w;
        cyc(DB_PC_PLUS_4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exec(input logic [15:0] w);
        fetch(w);
        cyc(DB_IR_R1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(DB_RF,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (w[12]) begin
            cyc(DB_IR_R2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            cyc(DB_IR_R2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc(DB_RF,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(DB_IR_RD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(DB_ALU,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_reg(input logic [2:0] r, input logic [5:0] v);
        exec(mk(3'd7, 1'b1, r, 3'd0, v));
    endtask

    logic [2:0] rsel;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        data_bus_sel = DB_ZERO; pc_load_en = 1'b0; ir_load_en = 1'b0; rf_write_read = 1'b0;
        alu_src1_load_en = 1'b0; alu_src2_load_en = 1'b0; sel_field_load_en = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(posedge clock); #1;
        chk("rst_instr_addr", {8'h00, instr_addr}, 16'h0000);
        chk("rst_imm", {15'd0, imm_instruction}, 16'h0000);
        chk("rst_flags", {14'd0, zero_flag, carry_flag}, 16'h0000);
        peek(DB_PC_PLUS_4, "rst_pc_plus_4", 8'h04);
        @(negedge clock); #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Register-register ADD: rf3 = rf1 + rf2
        set_reg(3'd1, 6'h05);
        set_reg(3'd2, 6'h07);
        exec(mk(3'd0, 1'b0, 3'd3, 3'd1, 6'd2));
        peek(DB_RF, "add_rr_result", 8'h0C);
        chk("add_rr_pc", {8'h00, instr_addr}, 16'h000C);
        chk("add_rr_flags", {14'd0, zero_flag, carry_flag}, 16'h0000);

        // Immediate ADD with carry: rf4 = 0 - 1 = FF, then rf5 = FF + 1
        exec(mk(3'd1, 1'b1, 3'd4, 3'd0, 6'd1));
        peek(DB_RF, "sub_ff_result", 8'hFF);
        exec(mk(3'd0, 1'b1, 3'd5, 3'd4, 6'd1));
        peek(DB_RF, "add_imm_result", 8'h00);
        chk("add_imm_flags", {14'd0, zero_flag, carry_flag}, 16'h0003);

        // SUB with borrow: 3 - 5
        set_reg(3'd1, 6'h03);
        exec(mk(3'd1, 1'b1, 3'd6, 3'd1, 6'd5));
        peek(DB_ALU, "sub_borrow_alu", 8'hFE);
        chk("sub_borrow_flags", {14'd0, zero_flag, carry_flag}, 16'h0001);

        // PC wrap from FC
        exec(mk(3'd1, 1'b1, 3'd7, 3'd0, 6'd4));
        cyc(DB_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pc_load_fc", {8'h00, instr_addr}, 16'h00FC);
        cyc(DB_PC_PLUS_4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pc_wrap", {8'h00, instr_addr}, 16'h0000);

        // Simultaneous strobes with bus 2B
        fetch(mk(3'd0, 1'b1, 3'd0, 3'd0, 6'h2B));
        chk("imm_bit", {15'd0, imm_instruction}, 16'h0001);
        cyc(DB_IR_R2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        peek(DB_ALU, "simul_src_sum", 8'h56);
        peek(DB_RF, "simul_sel_field", 8'h0C);

        // Asynchronous reset mid-cycle with all strobes asserted
        set_reg(3'd0, 6'h09);
        peek(DB_RF, "pre_rst_rf0", 8'h09);
        data_bus_sel = DB_RF; pc_load_en = 1'b1; ir_load_en = 1'b1; rf_write_read = 1'b1;
        alu_src1_load_en = 1'b1; alu_src2_load_en = 1'b1; sel_field_load_en = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_instr_addr", {8'h00, instr_addr}, 16'h0000);
        chk("mid_rst_imm", {15'd0, imm_instruction}, 16'h0000);
        chk("mid_rst_flags", {14'd0, zero_flag, carry_flag}, 16'h0000);
        chk("mid_rst_rf_bus", {8'h00, bus_value}, 16'h0000);
        @(posedge clock); #1;
        chk("rst_hold_instr_addr", {8'h00, instr_addr}, 16'h0000);
        chk("rst_hold_bus", {8'h00, bus_value}, 16'h0000);
        pc_load_en = 1'b0; ir_load_en = 1'b0; rf_write_read = 1'b0;
        alu_src1_load_en = 1'b0; alu_src2_load_en = 1'b0; sel_field_load_en = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Random strobes and bus selects, with occasional mid-cycle resets
        for (int n = 0; n < 800; n++) begin
            rsel = 3'($urandom_range(0, 7));
            data_bus_sel      = data_bus_t'(rsel);
            pc_load_en        = ($urandom_range(0, 5) == 0);
            ir_load_en        = ($urandom_range(0, 2) == 0);
            rf_write_read     = ($urandom_range(0, 2) == 0);
            alu_src1_load_en  = ($urandom_range(0, 2) == 0);
            alu_src2_load_en  = ($urandom_range(0, 2) == 0);
            sel_field_load_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 80) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            @(posedge clock); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
